i2s_tx: RTL and testbench

Serializes the stereo sample stream leaving the effects pipe into an I2S bitstream for the codec DAC. Accepts one `sample_pkg::sample_t` per `vld_i` pulse, with no back-pressure. Holds the sample in a one-frame buffer and transmits it in the next full LRCLK frame. Generates BCLK and LRCLK internally from `clk`; this block is the clock master.

---
 rtl/i2s_tx.sv | 176 +++++++++++++++++
 tb/tb_i2s_tx.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: serializes stereo samples into an I2S bitstream; this block is the BCLK/LRCLK master.
// Latency: a sample rides the next full frame; MSB leaves at most one frame plus one BCLK after vld_i.
// Backpressure: none; a second sample before the frame load overwrites the held one and pulses overflow_o.
// Build option: define I2S_TX_LJ_EN for left-justified output (no delay bit, LRCLK high = left slot).

package sample_pkg;
    typedef struct packed {
        logic [23:0] lc;
        logic [23:0] rc;
    } sample_t;
endpackage

module i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_HALF  = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [$bits(sample_pkg::sample_t)-1:0]  data_i,
    input  logic                                    vld_i,
    output logic                                    bclk_o,
    output logic                                    lrclk_o,
    output logic                                    sdata_o,
    output logic                                    underrun_o,
    output logic                                    overflow_o
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BC_W       = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_BITS - 1);
    localparam logic [BC_W-1:0]  BC_SLOT  = BC_W'(SLOT_WIDTH);
    localparam logic [BC_W-1:0]  BC_DATA  = BC_W'(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    sample_pkg::sample_t sample;
    assign sample = data_i;

    // clock generation state
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  bclk_q, bclk_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;

    // serial output state
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic [DATA_WIDTH-1:0] sreg_l_q, sreg_l_d;
    logic [DATA_WIDTH-1:0] sreg_r_q, sreg_r_d;

    // one-frame hold buffer
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  hold_vld_q, hold_vld_d;

    // status pulses
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;

    // decoded strobes
    logic                  div_wrap;
    logic                  fall;
    logic                  frame_start;
    logic                  right_slot;
    logic [BC_W-1:0]       slot_pos;
    logic                  in_data;

    // BCLK divider and frame bit counter; every serial change happens on the BCLK falling edge
    always_comb begin
        div_wrap    = (div_cnt_q == DIV_LAST);
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d      = div_wrap ? ~bclk_q : bclk_q;
        fall        = div_wrap & bclk_q;
        frame_start = fall & (bit_cnt_q == BC_LAST);
        bit_cnt_d   = bit_cnt_q;
        if (fall) begin
            bit_cnt_d = frame_start ? '0 : bit_cnt_q + 1'b1;
        end
        // slot decode looks at the position being entered, so outputs and counter move together
        right_slot = (bit_cnt_d >= BC_SLOT);
        slot_pos   = right_slot ? (bit_cnt_d - BC_SLOT) : bit_cnt_d;
`ifdef I2S_TX_LJ_EN
        in_data    = (slot_pos < BC_DATA);
`else
        in_data    = (slot_pos != '0) && (slot_pos <= BC_DATA);
`endif
    end

    // hold buffer: newest sample wins; overwrite counts as overflow unless the load consumed the old one
    always_comb begin
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        hold_vld_d = hold_vld_q;
        overflow_d = 1'b0;
        if (frame_start) begin
            hold_vld_d = 1'b0;
        end
        if (vld_i) begin
            hold_l_d   = sample.lc;
            hold_r_d   = sample.rc;
            hold_vld_d = 1'b1;
            overflow_d = hold_vld_q & ~frame_start;
        end
    end

    // frame load and MSB-first shift-out; the load is visible to the same fall so LJ can emit p0 data
    always_comb begin
        sreg_l_d   = sreg_l_q;
        sreg_r_d   = sreg_r_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        if (frame_start) begin
            // buffer contents as registered before this cycle; an empty buffer sends a muted frame
            sreg_l_d   = hold_vld_q ? hold_l_q : '0;
            sreg_r_d   = hold_vld_q ? hold_r_q : '0;
            underrun_d = ~hold_vld_q;
        end
        if (fall) begin
`ifdef I2S_TX_LJ_EN
            lrclk_d = ~right_slot;
`else
            lrclk_d = right_slot;
`endif
            sdata_d = 1'b0;
            if (in_data) begin
                if (right_slot) begin
                    sdata_d  = sreg_r_d[DATA_WIDTH-1];
                    sreg_r_d = {sreg_r_d[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    sdata_d  = sreg_l_d[DATA_WIDTH-1];
                    sreg_l_d = {sreg_l_d[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // state registers; reset parks the bit counter on the last bit so the first fall starts a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= BC_LAST;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            sreg_l_q   <= '0;
            sreg_r_q   <= '0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            hold_vld_q <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            sreg_l_q   <= sreg_l_d;
            sreg_r_q   <= sreg_r_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            hold_vld_q <= hold_vld_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign bclk_o     = bclk_q;
    assign lrclk_o    = lrclk_q;
    assign sdata_o    = sdata_q;
    assign underrun_o = underrun_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: receiver-side checks of i2s_tx against a frame-window model of sample delivery.
// Latency: observes each frame after its last BCLK rising edge.
// Backpressure: n/a; stimulus pulses vld_i freely.

module tb_i2s_tx;

    localparam int DW        = 24;
    localparam int SW        = 32;
    localparam int BH        = 2;
    localparam int FRAME_CYC = 2 * SW * 2 * BH;
    localparam int FIRST     = 2 * BH;
    localparam int MAXF      = 12;

`ifdef I2S_TX_LJ_EN
    localparam logic [63:0] LR_EXP  = {32'hFFFF_FFFF, 32'h0};
    localparam logic        LR_LEFT = 1'b1;
`else
    localparam logic [63:0] LR_EXP  = {32'h0, 32'hFFFF_FFFF};
    localparam logic        LR_LEFT = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [47:0] data_i = '0;
    logic        vld_i  = 1'b0;
    logic        bclk_o, lrclk_o, sdata_o, underrun_o, overflow_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_HALF(BH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .vld_i      (vld_i),
        .bclk_o     (bclk_o),
        .lrclk_o    (lrclk_o),
        .sdata_o    (sdata_o),
        .underrun_o (underrun_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // clk edges since reset release; edge n leaves cyc == n
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // receiver: samples on BCLK rising edges, plus flag/pulse logging
    logic [63:0] rx_dat [MAXF];
    logic [63:0] rx_lr  [MAXF];
    int          rise_cnt, last_rise, per_bad, sdata_ones;
    int          und_q[$];
    int          ovf_q[$];
    logic        bclk_prev;

    always @(negedge clk) begin
        if (rst) begin
            rise_cnt   = 0;
            last_rise  = 0;
            per_bad    = 0;
            sdata_ones = 0;
            bclk_prev  = 1'b0;
            und_q.delete();
            ovf_q.delete();
            for (int i = 0; i < MAXF; i++) begin
                rx_dat[i] = 'x;
                rx_lr[i]  = 'x;
            end
        end else begin
            if (underrun_o) und_q.push_back(cyc);
            if (overflow_o) ovf_q.push_back(cyc);
            if (sdata_o)    sdata_ones++;
            if (bclk_o && !bclk_prev && cyc >= FIRST) begin
                if (rise_cnt > 0 && (cyc - last_rise) != 2 * BH) per_bad++;
                last_rise = cyc;
                if (rise_cnt / 64 < MAXF) begin
                    rx_dat[rise_cnt / 64][63 - (rise_cnt % 64)] = sdata_o;
                    rx_lr[rise_cnt / 64][63 - (rise_cnt % 64)]  = lrclk_o;
                end
                rise_cnt++;
            end
            bclk_prev = bclk_o;
        end
    end

    // reference model: sample log, frame windows and wire image
    int          m_edge[$];
    logic [47:0] m_dat[$];

    function automatic int fstart(input int k);
        return FIRST + k * FRAME_CYC;
    endfunction

    // which frame a sample written at edge n ends up in
    function automatic int win(input int n);
        return (n < FIRST) ? 0 : (n - FIRST) / FRAME_CYC + 1;
    endfunction

    // {present, lc, rc} of the sample carried by frame k (latest write in its window)
    function automatic logic [48:0] model_frame(input int k);
        logic [48:0] res;
        res = '0;
        foreach (m_edge[i]) if (win(m_edge[i]) == k) res = {1'b1, m_dat[i]};
        return res;
    endfunction

    function automatic logic [63:0] wire_bits(input logic [47:0] s);
`ifdef I2S_TX_LJ_EN
        return {s[47:24], 8'h00, s[23:0], 8'h00};
`else
        return {1'b0, s[47:24], 7'h00, 1'b0, s[23:0], 7'h00};
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        vld_i = 1'b0;
        repeat (3) @(negedge clk);
        m_edge.delete();
        m_dat.delete();
        rst = 1'b0;
    endtask

    task automatic run_to(input int c);
        int g;
        g = 0;
        while (cyc < c && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < c) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_to: cycle %0d, wanted %0d", cyc, c);
        end
    endtask

    // call at a negedge; the sample is taken at the next edge
    task automatic send(input logic [23:0] l, input logic [23:0] r);
        data_i = {l, r};
        vld_i  = 1'b1;
        m_edge.push_back(cyc + 1);
        m_dat.push_back({l, r});
        @(negedge clk);
        vld_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bclk_o, lrclk_o, sdata_o, underrun_o, overflow_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bclk_o, lrclk_o, sdata_o, underrun_o, overflow_o});
        end
        do_reset();
        run_to(FIRST - 1);
        n_cmp++;
        if (bclk_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_bclk_high: got %b expected 1", bclk_o);
        end
        run_to(FIRST);
        n_cmp++;
        if ({bclk_o, lrclk_o, underrun_o} !== {1'b0, LR_LEFT, 1'b1}) begin
            n_bad++;
            $display("FAIL first_fall: got %b expected %b", {bclk_o, lrclk_o, underrun_o},
                     {1'b0, LR_LEFT, 1'b1});
        end
    endtask

    task automatic test_basic();
        do_reset();
        send(24'h800001, 24'h7FFFFF);
        run_to(fstart(1) + FRAME_CYC);
        n_cmp++;
        if (rx_dat[0] !== wire_bits({24'h800001, 24'h7FFFFF})) begin
            n_bad++;
            $display("FAIL basic_frame: got %h expected %h", rx_dat[0],
                     wire_bits({24'h800001, 24'h7FFFFF}));
        end
        n_cmp++;
        if (rx_lr[0] !== LR_EXP) begin
            n_bad++;
            $display("FAIL basic_lrclk: got %h expected %h", rx_lr[0], LR_EXP);
        end
        n_cmp++;
        if (per_bad !== 0 || rise_cnt < 128) begin
            n_bad++;
            $display("FAIL bclk_period: bad=%0d rises=%0d expected bad=0 rises>=128", per_bad, rise_cnt);
        end
        n_cmp++;
        if (und_q.size() !== 1 || und_q[0] !== fstart(1)) begin
            n_bad++;
            $display("FAIL basic_underrun: got %0d pulses expected 1 at %0d", und_q.size(), fstart(1));
        end
    endtask

    task automatic test_underrun();
        do_reset();
        run_to(fstart(2) + 100);
        n_cmp++;
        if (und_q.size() !== 3) begin
            n_bad++;
            $display("FAIL underrun_count: got %0d expected 3", und_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (und_q[k] !== fstart(k)) begin
                    n_bad++;
                    $display("FAIL underrun_time%0d: got %0d expected %0d", k, und_q[k], fstart(k));
                end
            end
        end
        n_cmp++;
        if (sdata_ones !== 0) begin
            n_bad++;
            $display("FAIL underrun_mute: got %0d ones expected 0", sdata_ones);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        run_to(50);
        send(24'h111111, 24'h222222);
        repeat (9) @(negedge clk);
        send(24'h333333, 24'h444444);
        run_to(fstart(1) + FRAME_CYC);
        n_cmp++;
        if (ovf_q.size() !== 1 || ovf_q[0] !== 61) begin
            n_bad++;
            $display("FAIL overflow_pulse: got %0d pulses (first %0d) expected 1 at 61",
                     ovf_q.size(), (ovf_q.size() > 0) ? ovf_q[0] : -1);
        end
        n_cmp++;
        if (rx_dat[1] !== wire_bits({24'h333333, 24'h444444})) begin
            n_bad++;
            $display("FAIL overflow_frame: got %h expected %h", rx_dat[1],
                     wire_bits({24'h333333, 24'h444444}));
        end
    endtask

    task automatic test_load_coincide();
        do_reset();
        run_to(FIRST - 1);
        send(24'h5A5A5A, 24'hC3C3C3);
        run_to(fstart(1) + FRAME_CYC);
        n_cmp++;
        if (und_q.size() !== 1 || und_q[0] !== FIRST) begin
            n_bad++;
            $display("FAIL coincide_underrun: got %0d pulses expected 1 at %0d", und_q.size(), FIRST);
        end
        n_cmp++;
        if (rx_dat[0] !== 64'h0) begin
            n_bad++;
            $display("FAIL coincide_mute: got %h expected 0", rx_dat[0]);
        end
        n_cmp++;
        if (rx_dat[1] !== wire_bits({24'h5A5A5A, 24'hC3C3C3})) begin
            n_bad++;
            $display("FAIL coincide_next: got %h expected %h", rx_dat[1],
                     wire_bits({24'h5A5A5A, 24'hC3C3C3}));
        end
        n_cmp++;
        if (ovf_q.size() !== 0) begin
            n_bad++;
            $display("FAIL coincide_overflow: got %0d pulses expected 0", ovf_q.size());
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        send(24'h123456, 24'h654321);
        run_to(20);
        send(24'hABCDEF, 24'hFEDCBA);
        run_to(FIRST + 4 * BH * 20);
        n_cmp++;
        if (lrclk_o !== ~LR_LEFT) begin
            n_bad++;
            $display("FAIL mid_lrclk: got %b expected %b", lrclk_o, ~LR_LEFT);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bclk_o, lrclk_o, sdata_o, underrun_o, overflow_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %b expected 00000",
                     {bclk_o, lrclk_o, sdata_o, underrun_o, overflow_o});
        end
        m_edge.delete();
        m_dat.delete();
        rst = 1'b0;
        run_to(FIRST);
        n_cmp++;
        if (underrun_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_restart_underrun: got %b expected 1", underrun_o);
        end
        run_to(fstart(0) + FRAME_CYC);
        n_cmp++;
        if (rx_dat[0] !== 64'h0) begin
            n_bad++;
            $display("FAIL mid_restart_mute: got %h expected 0", rx_dat[0]);
        end
    endtask

    task automatic test_random();
        int          ns, gap, nexp, nund;
        bit          found, dup;
        logic [48:0] m;
        logic [63:0] exp;
        int          exp_ovf[$];
        do_reset();
        while (cyc < fstart(6)) begin
            if ($urandom_range(0, 5) == 0) begin
                ns = (cyc < FIRST) ? FIRST : fstart((cyc - FIRST) / FRAME_CYC + 1);
                run_to(ns - 1);
            end else begin
                gap = $urandom_range(0, 150);
                repeat (gap) @(negedge clk);
            end
            send(24'($urandom), 24'($urandom));
        end
        run_to(fstart(7) + FRAME_CYC);
        nexp = 0;
        for (int k = 0; k < 8; k++) begin
            m   = model_frame(k);
            exp = m[48] ? wire_bits(m[47:0]) : 64'h0;
            if (!m[48]) nexp++;
            n_cmp++;
            if (rx_dat[k] !== exp) begin
                n_bad++;
                $display("FAIL rand_frame%0d: got %h expected %h", k, rx_dat[k], exp);
            end
            n_cmp++;
            if (rx_lr[k] !== LR_EXP) begin
                n_bad++;
                $display("FAIL rand_lrclk%0d: got %h expected %h", k, rx_lr[k], LR_EXP);
            end
            found = 1'b0;
            foreach (und_q[i]) if (und_q[i] == fstart(k)) found = 1'b1;
            n_cmp++;
            if (found !== !m[48]) begin
                n_bad++;
                $display("FAIL rand_underrun%0d: got %b expected %b", k, found, !m[48]);
            end
        end
        nund = 0;
        foreach (und_q[i]) if (und_q[i] <= fstart(7)) nund++;
        n_cmp++;
        if (nund !== nexp) begin
            n_bad++;
            $display("FAIL rand_underrun_total: got %0d expected %0d", nund, nexp);
        end
        foreach (m_edge[i]) begin
            dup = 1'b0;
            for (int j = 0; j < i; j++) if (win(m_edge[j]) == win(m_edge[i])) dup = 1'b1;
            if (dup) exp_ovf.push_back(m_edge[i]);
        end
        n_cmp++;
        if (ovf_q.size() !== exp_ovf.size()) begin
            n_bad++;
            $display("FAIL rand_overflow_count: got %0d expected %0d", ovf_q.size(), exp_ovf.size());
        end else begin
            foreach (exp_ovf[i]) begin
                n_cmp++;
                if (ovf_q[i] !== exp_ovf[i]) begin
                    n_bad++;
                    $display("FAIL rand_overflow%0d: got %0d expected %0d", i, ovf_q[i], exp_ovf[i]);
                end
            end
        end
        n_cmp++;
        if (per_bad !== 0) begin
            n_bad++;
            $display("FAIL rand_bclk_period: got %0d bad periods expected 0", per_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overflow();
        test_load_coincide();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
